panel_write_queue: RTL
======================

Name: panel_write_queue

Overview:
Sits directly downstream of the UDP panel writer and consumes its single-cycle write strobes (enable mask, address, RGB data). Buffers strobes in a small FIFO, because the upstream has no backpressure. Serializes each strobe into one write per enabled panel on a shared frame-memory write port with a valid/ready handshake. Reports drops and queue occupancy for debug.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries
ADDR_BITS, 14, pixel address bits kept from in_addr (upper bits ignored)
NUM_PANELS, 6, width of panel enable mask; panel index field is 3 bits

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
in_en  in  6  panel enable mask; any bit set = one write strobe this cycle
in_wr  in  4  byte-write mask from upstream; bits [2:0] used (R,G,B lanes)
in_addr  in  16  pixel address; only [ADDR_BITS-1:0] used
in_wdat  in  24  RGB data {R[23:16],G[15:8],B[7:0]}
clr_stats  in  1  single-cycle pulse: clears drop_count and overflow
mem_wr_valid  out  1  memory write request
mem_wr_ready  in  1  memory accepts request when high with valid
mem_addr  out  17  {panel_idx[2:0], pixel_addr[13:0]}
mem_wdat  out  24  RGB data
mem_be  out  3  lane enables = in_wr[2:0] of the entry
fifo_level  out  DEPTH_LOG2+1  entries currently queued (excludes entry being issued)
overflow  out  1  sticky: at least one strobe dropped
drop_count  out  16  dropped strobes, saturating at 16'hFFFF

Behaviour:
- Reset (async assert, sync release) sets: mem_wr_valid=0, mem_addr=0, mem_wdat=0, mem_be=0, fifo_level=0, overflow=0, drop_count=0, FIFO pointers=0, FSM=IDLE.
- Push: a cycle with in_en!=0 writes one entry {in_en, in_wr[2:0], in_addr[13:0], in_wdat} into the FIFO. A cycle with in_en==0 is ignored.
- Full: a push while fifo_level==2^DEPTH_LOG2 is dropped, even if a pop occurs that cycle. On a drop, overflow<=1 and drop_count increments (saturating).
- clr_stats: clears overflow and drop_count. A drop in the same cycle as clr_stats leaves drop_count=1 and overflow=1.
- FSM has two states, IDLE and ISSUE.
- IDLE: if FIFO is non-empty, pop the head into a working register (mask, be, addr, data) and go to ISSUE. mem_wr_valid=0 in IDLE.
- ISSUE: mem_wr_valid=1. panel_idx = index of the lowest set bit of the working mask. mem_addr, mem_wdat and mem_be are registered and held stable while valid && !ready.
- On mem_wr_valid && mem_wr_ready, the issued bit is cleared. If mask bits remain, the next-lowest panel is presented the next cycle with no bubble.
- If the accepted bit was the last one and the FIFO is non-empty, the next entry is popped in the same cycle and presented the next cycle with no bubble. If the FIFO is empty, go to IDLE.
- Latency: with an empty queue and IDLE FSM, a strobe in cycle N gives mem_wr_valid=1 in cycle N+2.
- Throughput: one memory write per cycle while mem_wr_ready=1.
- fifo_level counts pushes minus pops. Simultaneous push and pop leaves it unchanged. Pointers wrap modulo 2^DEPTH_LOG2.
- mem_wr_valid never deasserts without a handshake, except on reset.
- Reset mid-operation abandons the in-flight entry and all queued entries; nothing is replayed.

Test Plan:
- Single strobe in_en=6'b000001, addr=16'h0123, wdat=24'h3F2A15, in_wr=4'b0111, mem_wr_ready=1 -> one write at cycle N+2: mem_addr=17'h00123, mem_wdat=24'h3F2A15, mem_be=3'b111; valid for exactly 1 cycle.
- in_en=6'b101010, addr=16'h0010 -> three consecutive writes with mem_addr = {1,14'h10}, {3,14'h10}, {5,14'h10}, in that order, no gaps.
- mem_wr_ready held low 5 cycles during ISSUE -> valid stays high and addr/data/be are stable throughout; the write completes on the first ready cycle.
- mem_wr_ready=0, 18 strobes pushed (DEPTH_LOG2=4) -> fifo_level=16 (first strobe already in the working register), overflow=1, drop_count=1. Release ready -> 17 entries drained in push order.
- drop_count preset to 16'hFFFE, then 3 drops -> drop_count=16'hFFFF. clr_stats together with a drop -> drop_count=1, overflow=1.
- reset_n pulsed low mid-ISSUE with 4 entries queued -> mem_wr_valid=0 immediately (async), fifo_level=0. After release, no writes occur until a new strobe.

Source files
------------

// File: rtl/panel_write_queue_if.sv
// Strobe-in / memory-write-out bundle for panel_write_queue.
// The slave modport is the queue's view; master is whoever drives strobes and owns the memory port.
interface panel_write_queue_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ADDR_BITS  = 14,
  parameter int NUM_PANELS = 6
);
  logic [NUM_PANELS-1:0]  in_en;
  logic [3:0]             in_wr;
  logic [15:0]            in_addr;
  logic [23:0]            in_wdat;
  logic                   clr_stats;
  logic                   mem_wr_valid;
  logic                   mem_wr_ready;
  logic [ADDR_BITS+2:0]   mem_addr;
  logic [23:0]            mem_wdat;
  logic [2:0]             mem_be;
  logic [DEPTH_LOG2:0]    fifo_level;
  logic                   overflow;
  logic [15:0]            drop_count;

  modport slave (
    input  in_en, in_wr, in_addr, in_wdat, clr_stats, mem_wr_ready,
    output mem_wr_valid, mem_addr, mem_wdat, mem_be, fifo_level, overflow, drop_count
  );

  modport master (
    output in_en, in_wr, in_addr, in_wdat, clr_stats, mem_wr_ready,
    input  mem_wr_valid, mem_addr, mem_wdat, mem_be, fifo_level, overflow, drop_count
  );
endinterface

// File: rtl/panel_write_queue.sv
// Buffers panel write strobes and serializes each into one memory write per enabled panel.
// state | meaning
// IDLE  | no entry in flight; pops the FIFO head as soon as one is queued
// ISSUE | presenting the lowest remaining panel of the working entry
module panel_write_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ADDR_BITS  = 14,
  parameter int NUM_PANELS = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  panel_write_queue_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic [NUM_PANELS-1:0] mask;
    logic [2:0]            be;
    logic [ADDR_BITS-1:0]  addr;
    logic [23:0]           data;
  } entry_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  entry_t                fifo_mem [DEPTH];
  entry_t                new_entry;
  entry_t                head;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  full, empty, push, do_push, drop, pop, load;

  state_t                state_q, state_d;
  logic [NUM_PANELS-1:0] mask_q, mask_d, mask_rem;
  logic [2:0]            be_q, be_d;
  logic [ADDR_BITS-1:0]  paddr_q, paddr_d;
  logic [23:0]           data_q, data_d;
  logic [ADDR_BITS+2:0]  maddr_q, maddr_d;

  logic                  overflow_q;
  logic [15:0]           drop_count_q;

  logic                  unused_bits;
  assign unused_bits = ^{bus.in_wr[3], bus.in_addr[15:ADDR_BITS]};

  function automatic logic [2:0] low_idx(input logic [NUM_PANELS-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_PANELS - 1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign new_entry = {bus.in_en, bus.in_wr[2:0], bus.in_addr[ADDR_BITS-1:0], bus.in_wdat};
  assign head      = fifo_mem[rd_ptr_q];
  assign full      = (level_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty     = (level_q == '0);
  assign push      = |bus.in_en;
  // A full queue drops the strobe even if the FSM pops this same cycle.
  assign do_push   = push && !full;
  assign drop      = push && full;
  assign mask_rem  = mask_q & (mask_q - NUM_PANELS'(1));

  always_ff @(posedge clock) begin
    if (do_push) fifo_mem[wr_ptr_q] <= new_entry;
  end

  always_comb begin
    level_d = level_q;
    if (do_push && !pop)      level_d = level_q + (DEPTH_LOG2+1)'(1);
    else if (!do_push && pop) level_d = level_q - (DEPTH_LOG2+1)'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    be_d    = be_q;
    paddr_d = paddr_q;
    data_d  = data_q;
    maddr_d = maddr_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) load = 1'b1;
      end
      ISSUE: begin
        if (bus.mem_wr_ready) begin
          if (mask_rem != '0) begin
            mask_d  = mask_rem;
            maddr_d = {low_idx(mask_rem), paddr_q};
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            mask_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      mask_d  = head.mask;
      be_d    = head.be;
      paddr_d = head.addr;
      data_d  = head.data;
      maddr_d = {low_idx(head.mask), head.addr};
      state_d = ISSUE;
    end
  end

  assign pop = load;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      be_q    <= '0;
      paddr_q <= '0;
      data_q  <= '0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      be_q    <= be_d;
      paddr_q <= paddr_d;
      data_q  <= data_d;
      maddr_q <= maddr_d;
    end
  end

  // A drop coinciding with clr_stats must still be counted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (bus.clr_stats) begin
      overflow_q   <= drop;
      drop_count_q <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign bus.mem_wr_valid = (state_q == ISSUE);
  assign bus.mem_addr     = maddr_q;
  assign bus.mem_wdat     = data_q;
  assign bus.mem_be       = be_q;
  assign bus.fifo_level   = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.drop_count   = drop_count_q;
endmodule
